multicycle_controller: RTL and testbench

Sequencing FSM for the multi-cycle RV32I datapath. It drives every write enable and every `mux2`/`mux3` select of the shared-memory, single-ALU datapath: PC register, instruction register, register file, ALU source muxes and result mux. It decodes `op`/`funct3`/`funct7b5`, steps each instruction through its cycles, and stalls on a memory ready handshake.

---
 rtl/riscv_ctrl_pkg.sv | 64 ++++++
 rtl/alu_decoder.sv | 30 +++
 rtl/multicycle_controller.sv | 143 ++++++++++++++
 tb/tb_multicycle_controller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller and its datapath muxes.
// Covers state codes, opcodes, ALU operations, mux select codes and immediate formats.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALU op class handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALU op class plus funct fields onto an ALU operation code.
// op5 separates R-type (sub possible) from I-type (funct7b5 is immediate bits there).
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the shared-memory, single-ALU multi-cycle RV32I datapath.
// Handshake: a memory access in FETCH/MEMREAD/MEMWRITE completes on a rising edge where mem_ready is 1.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       illegal,
  output logic [3:0] state_o
);

  state_t     state, next_state;
  logic       ready;
  logic       pc_w, ir_w, mem_w, reg_w, ill;
  logic [1:0] alu_op;

  assign ready = WAIT_EN ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    pc_w       = 1'b0;
    ir_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    ill        = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    alu_op     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_w       = ready;
        pc_w       = ready;
        if (ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECUTER;
          OP_ITYPE:          next_state = S_EXECUTEI;
          OP_BRANCH:         next_state = S_BEQ;
          OP_JAL:            next_state = S_JAL;
          default:           next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        next_state = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        if (ready) next_state = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a  = SRCA_RD1;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w      = 1'b1;
        next_state = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RD1;
        alu_op     = ALUOP_SUB;
        pc_w       = zero;
        next_state = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_w       = 1'b1;
        next_state = S_ALUWB;
      end
      S_TRAP: begin
        ill = 1'b1;
      end
      default: next_state = S_TRAP;
    endcase
  end

  // Gating on reset keeps enables low while reset is held, even though FETCH follows mem_ready
  assign pc_write  = pc_w  & reset;
  assign ir_write  = ir_w  & reset;
  assign mem_write = mem_w & reset;
  assign reg_write = reg_w & reset;
  assign illegal   = ill   & reset;
  assign imm_src   = imm_src_of(op);
  assign state_o   = state;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed scenarios plus random instruction streams,
// all checked against an instruction-schedule model of the controller.
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_o;

  int checks = 0;
  int failures = 0;

  // Model: the expected state plus the remaining steps of the current instruction
  logic [3:0] cur = S_FETCH;
  logic [3:0] sched[$];

  multicycle_controller #(.WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] model_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] model_imm(input logic [6:0] o);
    case (o)
      7'b0000011, 7'b0010011: return 2'b00;
      7'b0100011:             return 2'b01;
      7'b1100011:             return 2'b10;
      7'b1101111:             return 2'b11;
      default:                return 2'b00;
    endcase
  endfunction

  // Step list an instruction walks after its fetch completes
  task automatic build_schedule(input logic [6:0] o);
    sched.delete();
    sched.push_back(S_DECODE);
    case (o)
      7'b0000011: begin sched.push_back(S_MEMADR); sched.push_back(S_MEMREAD); sched.push_back(S_MEMWB); end
      7'b0100011: begin sched.push_back(S_MEMADR); sched.push_back(S_MEMWRITE); end
      7'b0110011: begin sched.push_back(S_EXECUTER); sched.push_back(S_ALUWB); end
      7'b0010011: begin sched.push_back(S_EXECUTEI); sched.push_back(S_ALUWB); end
      7'b1100011: sched.push_back(S_BEQ);
      7'b1101111: begin sched.push_back(S_JAL); sched.push_back(S_ALUWB); end
      default:    sched.push_back(S_TRAP);
    endcase
  endtask

  task automatic check_outputs();
    logic e_pc, e_adr, e_ir, e_mw, e_rw, e_ill;
    logic [1:0] e_rs, e_a, e_b;
    logic [2:0] e_alu;
    e_pc = 0; e_adr = 0; e_ir = 0; e_mw = 0; e_rw = 0; e_ill = 0;
    e_rs = 0; e_a = 0; e_b = 0; e_alu = 0;
    case (cur)
      S_FETCH:    begin e_b = 2; e_rs = 2; e_ir = mem_ready; e_pc = mem_ready; end
      S_DECODE:   begin e_a = 1; e_b = 1; end
      S_MEMADR:   begin e_a = 2; e_b = 1; end
      S_MEMREAD:  e_adr = 1;
      S_MEMWB:    begin e_rs = 1; e_rw = 1; end
      S_MEMWRITE: begin e_adr = 1; e_mw = 1; end
      S_EXECUTER: begin e_a = 2; e_alu = model_alu(op, funct3, funct7b5); end
      S_EXECUTEI: begin e_a = 2; e_b = 1; e_alu = model_alu(op, funct3, funct7b5); end
      S_ALUWB:    e_rw = 1;
      S_BEQ:      begin e_a = 2; e_alu = 3'b001; e_pc = zero; end
      S_JAL:      begin e_a = 1; e_b = 2; e_pc = 1; end
      default:    e_ill = 1;
    endcase
    if (!reset) begin e_pc = 0; e_ir = 0; e_mw = 0; e_rw = 0; e_ill = 0; end
    chk("state_o", state_o, cur);
    chk("pc_write", pc_write, e_pc);
    chk("adr_src", adr_src, e_adr);
    chk("ir_write", ir_write, e_ir);
    chk("mem_write", mem_write, e_mw);
    chk("reg_write", reg_write, e_rw);
    chk("result_src", result_src, e_rs);
    chk("alu_src_a", alu_src_a, e_a);
    chk("alu_src_b", alu_src_b, e_b);
    chk("alu_control", alu_control, e_alu);
    chk("imm_src", imm_src, model_imm(op));
    chk("illegal", illegal, e_ill);
    chk("mw_excl", mem_write & (reg_write | ir_write), 1'b0);
  endtask

  task automatic advance();
    case (cur)
      S_FETCH: if (mem_ready) begin build_schedule(op); cur = sched.pop_front(); end
      S_MEMREAD, S_MEMWRITE: if (mem_ready) cur = (sched.size() != 0) ? sched.pop_front() : S_FETCH;
      S_TRAP: cur = S_TRAP;
      default: cur = (sched.size() != 0) ? sched.pop_front() : S_FETCH;
    endcase
  endtask

  // One clock: drive inputs on the falling edge, check, then advance the model
  task automatic cyc(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic rdy);
    @(negedge clk);
    reset = rst; op = o; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = rdy;
    #1;
    if (!reset) begin cur = S_FETCH; sched.delete(); end
    check_outputs();
    if (reset) advance();
  endtask

  initial begin
    int cnt_rw, cnt_mw, n_cyc;
    logic [6:0] r_op;
    logic [2:0] r_f3;
    logic       r_f7;
    logic [6:0] legal_ops[6];
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

    // reset held with mem_ready high
    for (int i = 0; i < 3; i++) cyc(0, 7'b0110011, 3'b000, 0, 0, 1);
    chk("rst_state", state_o, 4'd0);
    chk("rst_ir_write", ir_write, 1'b0);
    chk("rst_pc_write", pc_write, 1'b0);

    // add
    cyc(1, 7'b0110011, 3'b000, 0, 0, 1);
    chk("first_ir_write", ir_write, 1'b1);
    chk("first_pc_write", pc_write, 1'b1);
    chk("first_srcb", alu_src_b, 2'b10);
    cyc(1, 7'b0110011, 3'b000, 0, 0, 1);
    cyc(1, 7'b0110011, 3'b000, 0, 0, 1);
    chk("add_state", state_o, 4'd6);
    chk("add_alu", alu_control, 3'b000);
    chk("add_no_rw", reg_write, 1'b0);
    cyc(1, 7'b0110011, 3'b000, 0, 0, 1);
    chk("add_wb", reg_write, 1'b1);

    // sub
    for (int i = 0; i < 3; i++) cyc(1, 7'b0110011, 3'b000, 1, 0, 1);
    chk("sub_alu", alu_control, 3'b001);
    cyc(1, 7'b0110011, 3'b000, 1, 0, 1);

    // lw with two stall cycles in MEMREAD: seven cycles total
    cnt_rw = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(1, 7'b0000011, 3'b010, 0, 0, (i == 3 || i == 4) ? 1'b0 : 1'b1);
      if (i >= 3 && i <= 5) chk("lw_adr_src", adr_src, 1'b1);
      if (reg_write) cnt_rw++;
    end
    chk("lw_rw_count", cnt_rw, 1);
    chk("lw_last_rw", reg_write, 1'b1);
    cyc(1, 7'b0100011, 3'b010, 0, 0, 1);
    chk("lw_back_fetch", state_o, 4'd0);

    // sw with one stall cycle (fetch already counted above)
    cnt_mw = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 7'b0100011, 3'b010, 0, 0, (i == 2) ? 1'b0 : 1'b1);
      if (mem_write) cnt_mw++;
    end
    chk("sw_mw_count", cnt_mw, 2);
    cyc(1, 7'b1100011, 3'b000, 0, 1, 1);
    chk("sw_back_fetch", state_o, 4'd0);

    // beq taken then not taken
    cyc(1, 7'b1100011, 3'b000, 0, 1, 1);
    cyc(1, 7'b1100011, 3'b000, 0, 1, 1);
    chk("beq_t_pc", pc_write, 1'b1);
    chk("beq_t_alu", alu_control, 3'b001);
    for (int i = 0; i < 3; i++) cyc(1, 7'b1100011, 3'b000, 0, 0, 1);
    chk("beq_nt_pc", pc_write, 1'b0);

    // jal
    for (int i = 0; i < 3; i++) cyc(1, 7'b1101111, 3'b000, 0, 0, 1);
    chk("jal_pc", pc_write, 1'b1);
    cyc(1, 7'b1101111, 3'b000, 0, 0, 1);
    chk("jal_wb", reg_write, 1'b1);

    // reset pulse while a store is stalled in MEMWRITE
    for (int i = 0; i < 4; i++) cyc(1, 7'b0100011, 3'b010, 0, 0, (i == 3) ? 1'b0 : 1'b1);
    chk("sw_in_memwrite", mem_write, 1'b1);
    cyc(0, 7'b0100011, 3'b010, 0, 0, 0);
    chk("abort_mw", mem_write, 1'b0);
    chk("abort_state", state_o, 4'd0);
    cyc(0, 7'b0100011, 3'b010, 0, 0, 1);

    // illegal opcode
    for (int i = 0; i < 5; i++) cyc(1, 7'b0000000, 3'b000, 0, 0, 1);
    chk("trap_state", state_o, 4'd11);
    chk("trap_illegal", illegal, 1'b1);
    chk("trap_pc", pc_write, 1'b0);
    cyc(0, 7'b0000000, 3'b000, 0, 0, 1);

    // random instruction streams
    r_op = legal_ops[0]; r_f3 = 0; r_f7 = 0;
    n_cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (cur == S_FETCH) begin
        if ($urandom_range(0, 31) == 0) r_op = 7'($urandom_range(0, 127));
        else r_op = legal_ops[$urandom_range(0, 5)];
        r_f3 = 3'($urandom_range(0, 7));
        r_f7 = 1'($urandom_range(0, 1));
      end
      if (cur == S_TRAP) n_cyc++;
      if (n_cyc >= 3 || $urandom_range(0, 299) == 0) begin
        cyc(0, r_op, r_f3, r_f7, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        n_cyc = 0;
      end else begin
        cyc(1, r_op, r_f3, r_f7, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
